overlay_mixer: RTL and testbench

//  Parametrised successor to the single-bit text overlay command stage.

---
 rtl/overlay_mixer.sv | 164 ++++++++++++++++
 tb/tb_overlay_mixer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_mixer.sv
// overlay_mixer
//   Merges a font-ROM dot stream with incoming video into full-colour output
//   pixels. Supports pass/opaque/transparent/inverse overlay modes, text blink
//   and a cursor cell, and keeps the legacy overlay-on "com" strobe.
//   Video, pixel qualifier and cursor flag are delayed DOT_DLY cycles so they
//   line up with the dot coming back from the font ROM.
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   frame_start   one-cycle pulse per frame: loads shadow config, advances blink
//   pixel_en      active-video qualifier (aligned with video_in)
//   video_in      underlying video pixel
//   cursor_hit    pixel lies inside the cursor cell (aligned with video_in)
//   dot           font dot, DOT_DLY cycles after its pixel
//   mode          00 pass, 01 opaque, 10 transparent, 11 inverse (shadowed)
//   fg_color      text colour (shadowed)
//   bg_color      background colour (shadowed)
//   blink_en      hide text during blink-off phase (shadowed)
//   pix_out       registered mixed pixel
//   pix_valid     pix_out belongs to an active pixel
//   com           registered overlay-on strobe, polarity set by COM_ACTIVE_LOW
module overlay_mixer #(
   parameter int PIX_W          = 24,
   parameter int DOT_DLY        = 2,
   parameter int BLINK_FRAMES   = 30,
   parameter int COM_ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             pixel_en,
   input  logic [PIX_W-1:0] video_in,
   input  logic             cursor_hit,
   input  logic             dot,
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] fg_color,
   input  logic [PIX_W-1:0] bg_color,
   input  logic             blink_en,
   output logic [PIX_W-1:0] pix_out,
   output logic             pix_valid,
   output logic             com
);

   localparam int   BCW     = $clog2(BLINK_FRAMES) + 1;
   localparam logic COM_OFF = (COM_ACTIVE_LOW != 0);

   logic [1:0]       sh_mode;
   logic [PIX_W-1:0] sh_fg;
   logic [PIX_W-1:0] sh_bg;
   logic             sh_blink_en;
   logic [BCW-1:0]   blink_cnt;
   logic             blink_ph;

   logic             dl_en;
   logic [PIX_W-1:0] dl_v;
   logic             dl_c;

   // Alignment delay line; DOT_DLY=0 means the dot arrives with its pixel.
   if (DOT_DLY == 0) begin : g_no_dly
      assign dl_en = pixel_en;
      assign dl_v  = video_in;
      assign dl_c  = cursor_hit;
   end else begin : g_dly
      logic             en_pipe [DOT_DLY];
      logic [PIX_W-1:0] v_pipe  [DOT_DLY];
      logic             c_pipe  [DOT_DLY];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DOT_DLY; i++) begin
               en_pipe[i] <= 1'b0;
               v_pipe[i]  <= '0;
               c_pipe[i]  <= 1'b0;
            end
         end else begin
            en_pipe[0] <= pixel_en;
            v_pipe[0]  <= video_in;
            c_pipe[0]  <= cursor_hit;
            for (int i = 1; i < DOT_DLY; i++) begin
               en_pipe[i] <= en_pipe[i-1];
               v_pipe[i]  <= v_pipe[i-1];
               c_pipe[i]  <= c_pipe[i-1];
            end
         end
      end

      assign dl_en = en_pipe[DOT_DLY-1];
      assign dl_v  = v_pipe[DOT_DLY-1];
      assign dl_c  = c_pipe[DOT_DLY-1];
   end

   // Shadow config and blink phase change only at frame boundaries, so a
   // frame is always drawn with one consistent set of settings.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_mode     <= 2'b00;
         sh_fg       <= '0;
         sh_bg       <= '0;
         sh_blink_en <= 1'b0;
         blink_cnt   <= '0;
         blink_ph    <= 1'b0;
      end else if (frame_start) begin
         sh_mode     <= mode;
         sh_fg       <= fg_color;
         sh_bg       <= bg_color;
         sh_blink_en <= blink_en;
         if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   logic             d_eff;
   logic [PIX_W-1:0] mix_pix;
   logic             mix_on;

   always_comb begin
      d_eff   = dot & ~(sh_blink_en & blink_ph);
      mix_pix = dl_v;
      mix_on  = 1'b0;
      case (sh_mode)
         2'b01: begin
            mix_pix = d_eff ? sh_fg : sh_bg;
            mix_on  = d_eff;
         end
         2'b10: begin
            mix_pix = d_eff ? sh_fg : dl_v;
            mix_on  = d_eff;
         end
         2'b11: begin
            mix_pix = d_eff ? sh_bg : sh_fg;
            mix_on  = ~d_eff;
         end
         default: begin
            mix_pix = dl_v;
            mix_on  = 1'b0;
         end
      endcase
      // Cursor inverts the mixed pixel, and blinks with the text phase.
      if (dl_c && !blink_ph && (sh_mode != 2'b00)) begin
         mix_pix = ~mix_pix;
         mix_on  = ~mix_on;
      end
      if (!dl_en) begin
         mix_pix = '0;
         mix_on  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_out   <= '0;
         pix_valid <= 1'b0;
         com       <= COM_OFF;
      end else begin
         pix_out   <= mix_pix;
         pix_valid <= dl_en;
         com       <= mix_on ^ COM_OFF;
      end
   end

endmodule

// File: tb/tb_overlay_mixer.sv
module tb_overlay_mixer;

   localparam int PW  = 24;
   localparam int D_M = 2;
   localparam int BF  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, frame_start, pixel_en, cursor_hit, dot, blink_en;
   logic [1:0]    mode;
   logic [PW-1:0] video_in, fg_color, bg_color;

   logic [PW-1:0] pix_m, pix_l;
   logic          val_m, val_l, com_m, com_l;

   overlay_mixer #(.PIX_W(PW), .DOT_DLY(D_M), .BLINK_FRAMES(BF), .COM_ACTIVE_LOW(1)) u_dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_en(pixel_en),
      .video_in(video_in), .cursor_hit(cursor_hit), .dot(dot), .mode(mode),
      .fg_color(fg_color), .bg_color(bg_color), .blink_en(blink_en),
      .pix_out(pix_m), .pix_valid(val_m), .com(com_m));

   overlay_mixer #(.PIX_W(PW), .DOT_DLY(0), .BLINK_FRAMES(BF), .COM_ACTIVE_LOW(1)) u_leg (
      .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_en(pixel_en),
      .video_in(video_in), .cursor_hit(cursor_hit), .dot(dot), .mode(mode),
      .fg_color(fg_color), .bg_color(bg_color), .blink_en(blink_en),
      .pix_out(pix_l), .pix_valid(val_l), .com(com_l));

   int checks   = 0;
   int failures = 0;

   // Reference model: input history (index 0 = sample from previous edge),
   // number of frame_starts since reset, and config captured at last frame_start.
   logic          h_e [16];
   logic [PW-1:0] h_v [16];
   logic          h_c [16];
   int            nframes;
   logic [1:0]    s_mode;
   logic [PW-1:0] s_fg, s_bg;
   logic          s_be;

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void mix_ref(input int dly, output logic [PW-1:0] p,
                                   output logic v, output logic cm);
      logic          e, c, d, on, ph;
      logic [PW-1:0] vv;
      e  = (dly == 0) ? pixel_en   : h_e[dly-1];
      vv = (dly == 0) ? video_in   : h_v[dly-1];
      c  = (dly == 0) ? cursor_hit : h_c[dly-1];
      ph = ((nframes / BF) % 2) == 1;
      d  = dot && !(s_be && ph);
      case (s_mode)
         2'd0:    begin p = vv;              on = 1'b0; end
         2'd1:    begin p = d ? s_fg : s_bg; on = d;    end
         2'd2:    begin p = d ? s_fg : vv;   on = d;    end
         default: begin p = d ? s_bg : s_fg; on = !d;   end
      endcase
      if (c && !ph && s_mode != 2'd0) begin
         p  = ~p;
         on = !on;
      end
      v = e;
      if (!e) begin
         p  = '0;
         on = 1'b0;
      end
      cm = !on;
      if (rst) begin
         p  = '0;
         v  = 1'b0;
         cm = 1'b1;
      end
   endfunction

   task automatic step();
      logic [PW-1:0] ep_m, ep_l;
      logic          ev_m, ev_l, ec_m, ec_l;
      mix_ref(D_M, ep_m, ev_m, ec_m);
      mix_ref(0,   ep_l, ev_l, ec_l);
      @(posedge clk);
      for (int k = 15; k > 0; k--) begin
         h_e[k] = h_e[k-1];
         h_v[k] = h_v[k-1];
         h_c[k] = h_c[k-1];
      end
      h_e[0] = pixel_en;
      h_v[0] = video_in;
      h_c[0] = cursor_hit;
      if (rst) begin
         for (int k = 0; k < 16; k++) begin
            h_e[k] = 1'b0;
            h_v[k] = '0;
            h_c[k] = 1'b0;
         end
         nframes = 0;
         s_mode  = 2'd0;
         s_fg    = '0;
         s_bg    = '0;
         s_be    = 1'b0;
      end else if (frame_start) begin
         nframes++;
         s_mode = mode;
         s_fg   = fg_color;
         s_bg   = bg_color;
         s_be   = blink_en;
      end
      #1;
      check("m_pix",   pix_m, ep_m);
      check("m_valid", PW'(val_m), PW'(ev_m));
      check("m_com",   PW'(com_m), PW'(ec_m));
      check("l_pix",   pix_l, ep_l);
      check("l_valid", PW'(val_l), PW'(ev_l));
      check("l_com",   PW'(com_l), PW'(ec_l));
   endtask

   task automatic set_pix(input logic en, input logic [PW-1:0] v, input logic c, input logic d);
      pixel_en   = en;
      video_in   = v;
      cursor_hit = c;
      dot        = d;
   endtask

   task automatic frame(input logic [1:0] m, input logic [PW-1:0] fg, input logic [PW-1:0] bg,
                        input logic be);
      mode        = m;
      fg_color    = fg;
      bg_color    = bg;
      blink_en    = be;
      frame_start = 1'b1;
      set_pix(1'b0, '0, 1'b0, 1'b0);
      step();
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         h_e[k] = 1'b0;
         h_v[k] = '0;
         h_c[k] = 1'b0;
      end
      nframes = 0;
      s_mode  = 2'd0;
      s_fg    = '0;
      s_bg    = '0;
      s_be    = 1'b0;
      frame_start = 1'b0;
      mode     = 2'd0;
      fg_color = '0;
      bg_color = '0;
      blink_en = 1'b0;

      // Reset held with an active pixel and dot present
      rst = 1'b1;
      set_pix(1'b1, 24'hFFFFFF, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_valid", PW'(val_m), '0);
         check("rst_pix",   pix_l, '0);
         check("rst_com",   PW'(com_l), PW'(1));
      end
      rst = 1'b0;

      // Legacy behaviour on the zero-delay instance
      frame(2'd1, 24'h00C0DE, 24'h0B0B0B, 1'b0);
      for (int i = 0; i < 4; i++) begin
         logic en, d;
         en = i[1];
         d  = i[0];
         set_pix(en, 24'h777777, 1'b0, d);
         step();
         check("legacy_com", PW'(com_l), PW'(!(en && d)));
         check("legacy_pix", pix_l, !en ? 24'h0 : (d ? 24'h00C0DE : 24'h0B0B0B));
      end

      // Dot alignment on the DOT_DLY=2 instance, transparent mode
      frame(2'd2, 24'hABCDEF, 24'h000000, 1'b0);
      for (int pass = 0; pass < 2; pass++) begin
         set_pix(1'b1, 24'h123456, 1'b0, 1'b0);
         step();
         set_pix(1'b0, 24'h000000, 1'b0, 1'b0);
         step();
         dot = (pass == 0);
         step();
         check("align_pix", pix_m, (pass == 0) ? 24'hABCDEF : 24'h123456);
         check("align_valid", PW'(val_m), PW'(1));
      end

      // Mode change outside frame_start is held off until the next frame
      frame(2'd1, 24'h112233, 24'h445566, 1'b0);
      mode = 2'd3;
      set_pix(1'b1, 24'h0, 1'b0, 1'b1);
      step();
      check("shadow_hold_pix", pix_l, 24'h112233);
      check("shadow_hold_com", PW'(com_l), PW'(0));
      frame(2'd3, 24'h112233, 24'h445566, 1'b0);
      set_pix(1'b1, 24'h0, 1'b0, 1'b1);
      step();
      check("shadow_new_pix", pix_l, 24'h445566);
      check("shadow_new_com", PW'(com_l), PW'(1));

      // Blink: text hidden only during the blink-off phase
      do_reset();
      for (int f = 1; f <= 4; f++) begin
         logic hidden;
         frame(2'd1, 24'hA0A0A0, 24'h0B0B0B, 1'b1);
         hidden = ((f / BF) % 2) == 1;
         set_pix(1'b1, 24'h0, 1'b0, 1'b1);
         step();
         check("blink_pix", pix_l, hidden ? 24'h0B0B0B : 24'hA0A0A0);
         check("blink_com", PW'(com_l), PW'(hidden));
      end

      // Cursor inversion, and pass mode ignoring the cursor
      do_reset();
      frame(2'd1, 24'hFF0000, 24'h000000, 1'b0);
      set_pix(1'b1, 24'h555555, 1'b1, 1'b1);
      step();
      check("cursor_pix", pix_l, 24'h00FFFF);
      check("cursor_com", PW'(com_l), PW'(1));
      frame(2'd0, 24'hFF0000, 24'h000000, 1'b0);
      set_pix(1'b1, 24'h555555, 1'b1, 1'b1);
      step();
      check("cursor_pass_pix", pix_l, 24'h555555);

      // Randomized traffic including config churn, frames and mid-line resets
      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         frame_start = ($urandom_range(0, 7) == 0);
         mode        = 2'($urandom_range(0, 3));
         fg_color    = PW'($urandom);
         bg_color    = PW'($urandom);
         blink_en    = 1'($urandom);
         set_pix(($urandom_range(0, 3) != 0), PW'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom));
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
